// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types, constants and helpers for the interrupt sequencer
package pic_pkg;

    localparam int          NUM_IR         = 8;
    localparam logic [2:0]  SPURIOUS_LEVEL = 3'd7;
    localparam logic [2:0]  FIXED_LOWEST   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ACK1    = 2'd2
    } seq_state_t;

    // Rotate right by n so that bit n of the input lands at bit 0.
    function automatic logic [NUM_IR-1:0] rotate_right(input logic [NUM_IR-1:0] v,
                                                       input logic [2:0]        n);
        logic [NUM_IR-1:0] r;
        logic [2:0]        k;
        for (int i = 0; i < NUM_IR; i++) begin
            k    = 3'(i) + n;
            r[i] = v[k];
        end
        return r;
    endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// rtl/interrupt_sequencer_if.sv - request/acknowledge/EOI bundle between CPU side and sequencer
interface interrupt_sequencer_if;
    import pic_pkg::*;

    logic [NUM_IR-1:0] interrupt_req_reg;
    logic [NUM_IR-1:0] interrupt_mask;
    logic              auto_eoi;
    logic              rotate_mode;
    logic              inta;
    logic              eoi_cmd;
    logic              eoi_specific;
    logic [2:0]        eoi_level;
    logic [4:0]        vector_base;
    logic              int_out;
    logic              freeze;
    logic [NUM_IR-1:0] clear_ir_line;
    logic [NUM_IR-1:0] in_service_reg;
    logic [7:0]        data_out;
    logic              data_out_valid;

    modport master (
        output interrupt_req_reg, interrupt_mask, auto_eoi, rotate_mode, inta,
               eoi_cmd, eoi_specific, eoi_level, vector_base,
        input  int_out, freeze, clear_ir_line, in_service_reg, data_out, data_out_valid
    );

    modport slave (
        input  interrupt_req_reg, interrupt_mask, auto_eoi, rotate_mode, inta,
               eoi_cmd, eoi_specific, eoi_level, vector_base,
        output int_out, freeze, clear_ir_line, in_service_reg, data_out, data_out_valid
    );
endinterface

// File: rtl/priority_resolver.sv
// rtl/priority_resolver.sv - picks the highest-priority set bit given the current lowest-priority level
module priority_resolver
    import pic_pkg::*;
(
    input  logic [NUM_IR-1:0] vec_i,
    input  logic [2:0]        lowest_i,
    output logic              valid_o,
    output logic [2:0]        level_o
);

    logic [2:0]        start;
    logic [NUM_IR-1:0] rot;
    logic [2:0]        idx;

    // Rotate so the highest-priority level sits at bit 0, then take the first set bit.
    always_comb begin
        start = lowest_i + 3'd1;
        rot   = rotate_right(vec_i, start);
        idx   = 3'd0;
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            if (rot[i]) idx = 3'(i);
        end
        valid_o = |rot;
        level_o = idx + start;
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - 8-line interrupt acknowledge sequencer with ISR, EOI and rotation
module interrupt_sequencer
    import pic_pkg::*;
(
    input logic                  clk,
    input logic                  reset,
    interrupt_sequencer_if.slave bus
);

    seq_state_t        state_q;
    logic [NUM_IR-1:0] isr_q, isr_d;
    logic [2:0]        lp_q, lp_d;
    logic [2:0]        winner_q;
    logic              spurious_q;
    logic              int_out_q;
    logic              freeze_q;
    logic [NUM_IR-1:0] clear_q;
    logic [7:0]        data_out_q;
    logic              valid_q;

    logic [2:0]        lp_eff;
    logic [NUM_IR-1:0] cand;
    logic              cand_valid, isr_valid;
    logic [2:0]        cand_level, isr_level;
    logic [2:0]        cand_rank, isr_rank;
    logic              eligible;
    logic [2:0]        eoi_target;
    logic              eoi_hit;

    assign lp_eff = bus.rotate_mode ? lp_q : FIXED_LOWEST;
    assign cand   = bus.interrupt_req_reg & ~bus.interrupt_mask;

    priority_resolver u_cand_res (
        .vec_i    (cand),
        .lowest_i (lp_eff),
        .valid_o  (cand_valid),
        .level_o  (cand_level)
    );

    priority_resolver u_isr_res (
        .vec_i    (isr_q),
        .lowest_i (lp_eff),
        .valid_o  (isr_valid),
        .level_o  (isr_level)
    );

    // Rank 0 is the highest priority; a candidate must outrank everything already in service.
    always_comb begin
        cand_rank  = cand_level - lp_eff - 3'd1;
        isr_rank   = isr_level - lp_eff - 3'd1;
        eligible   = cand_valid && (!isr_valid || (cand_rank < isr_rank));
        eoi_target = bus.eoi_specific ? bus.eoi_level : isr_level;
        eoi_hit    = bus.eoi_cmd && (bus.eoi_specific ? isr_q[bus.eoi_level] : isr_valid);
    end

    // ISR and rotation next state: EOI first, then the acknowledge set, then the auto-EOI clear.
    always_comb begin
        isr_d = isr_q;
        lp_d  = lp_q;
        if (eoi_hit) begin
            isr_d[eoi_target] = 1'b0;
            if (bus.rotate_mode) lp_d = eoi_target;
        end
        if (state_q == ST_PENDING && bus.inta && eligible) begin
            isr_d[cand_level] = 1'b1;
        end
        if (state_q == ST_ACK1 && bus.inta && bus.auto_eoi && !spurious_q) begin
            isr_d[winner_q] = 1'b0;
            if (bus.rotate_mode) lp_d = winner_q;
        end
        if (!bus.rotate_mode) lp_d = FIXED_LOWEST;
    end

    // Acknowledge FSM with registered outputs, updated on the falling edge.
    always_ff @(negedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            isr_q      <= '0;
            lp_q       <= FIXED_LOWEST;
            winner_q   <= SPURIOUS_LEVEL;
            spurious_q <= 1'b0;
            int_out_q  <= 1'b0;
            freeze_q   <= 1'b0;
            clear_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            isr_q   <= isr_d;
            lp_q    <= lp_d;
            clear_q <= '0;
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    freeze_q  <= 1'b0;
                    int_out_q <= eligible;
                    if (eligible) state_q <= ST_PENDING;
                end
                ST_PENDING: begin
                    if (bus.inta) begin
                        winner_q   <= eligible ? cand_level : SPURIOUS_LEVEL;
                        spurious_q <= !eligible;
                        if (eligible) clear_q <= 8'b0000_0001 << cand_level;
                        freeze_q   <= 1'b1;
                        int_out_q  <= 1'b0;
                        state_q    <= ST_ACK1;
                    end else begin
                        freeze_q  <= 1'b0;
                        int_out_q <= 1'b1;
                    end
                end
                ST_ACK1: begin
                    int_out_q <= 1'b0;
                    if (bus.inta) begin
                        data_out_q <= {bus.vector_base, winner_q};
                        valid_q    <= 1'b1;
                        freeze_q   <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else begin
                        freeze_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    freeze_q  <= 1'b0;
                    int_out_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.int_out        = int_out_q;
    assign bus.freeze         = freeze_q;
    assign bus.clear_ir_line  = clear_q;
    assign bus.in_service_reg = isr_q;
    assign bus.data_out       = data_out_q;
    assign bus.data_out_valid = valid_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - randomized and directed self-checking bench for interrupt_sequencer
module tb_interrupt_sequencer;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    interrupt_sequencer_if bus();

    interrupt_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [7:0] m_isr;
    int         m_lp;
    int         m_stage;   // 0 waiting, 1 requested, 2 first acknowledge taken
    int         m_win;
    bit         m_spur;
    logic       e_int, e_freeze, e_valid;
    logic [7:0] e_clear, e_dout;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic int rank_of(int lvl, int lp);
        return (lvl - lp - 1 + 16) % 8;
    endfunction

    function automatic int top_of(logic [7:0] v, int lp);
        for (int k = 0; k < 8; k++) begin
            int l;
            l = (lp + 1 + k) % 8;
            if (v[l]) return l;
        end
        return -1;
    endfunction

    task automatic model_step();
        int         lpe, ct, it, lvl;
        bit         elig, hit;
        logic [7:0] cand, nisr;
        int         nlp;
        if (reset) begin
            m_isr = 8'h00; m_lp = 7; m_stage = 0; m_win = 7; m_spur = 0;
            e_int = 0; e_freeze = 0; e_clear = 0; e_valid = 0; e_dout = 0;
            return;
        end
        lpe  = bus.rotate_mode ? m_lp : 7;
        cand = bus.interrupt_req_reg & ~bus.interrupt_mask;
        ct   = top_of(cand, lpe);
        it   = top_of(m_isr, lpe);
        elig = (ct >= 0) && (it < 0 || rank_of(ct, lpe) < rank_of(it, lpe));
        nisr = m_isr;
        nlp  = m_lp;
        if (bus.eoi_cmd) begin
            lvl = bus.eoi_specific ? int'(bus.eoi_level) : it;
            hit = bus.eoi_specific ? m_isr[bus.eoi_level] : (it >= 0);
            if (hit) begin
                nisr[lvl] = 1'b0;
                if (bus.rotate_mode) nlp = lvl;
            end
        end
        e_clear = 8'h00;
        e_valid = 1'b0;
        if (m_stage == 0) begin
            e_freeze = 0;
            e_int    = elig;
            if (elig) m_stage = 1;
        end else if (m_stage == 1) begin
            if (bus.inta) begin
                if (elig) begin
                    m_win = ct; m_spur = 0; nisr[ct] = 1'b1; e_clear[ct] = 1'b1;
                end else begin
                    m_win = 7; m_spur = 1;
                end
                e_freeze = 1; e_int = 0; m_stage = 2;
            end else begin
                e_int = 1; e_freeze = 0;
            end
        end else begin
            e_int = 0;
            if (bus.inta) begin
                e_dout   = {bus.vector_base, 3'(m_win)};
                e_valid  = 1;
                e_freeze = 0;
                m_stage  = 0;
                if (bus.auto_eoi && !m_spur) begin
                    nisr[m_win] = 1'b0;
                    if (bus.rotate_mode) nlp = m_win;
                end
            end else begin
                e_freeze = 1;
            end
        end
        if (!bus.rotate_mode) nlp = 7;
        m_isr = nisr;
        m_lp  = nlp;
    endtask

    task automatic cyc(input logic [7:0] req, input logic ia, input logic eo,
                       input logic sp, input logic [2:0] lv);
        @(posedge clk);
        bus.interrupt_req_reg = req;
        bus.inta              = ia;
        bus.eoi_cmd           = eo;
        bus.eoi_specific      = sp;
        bus.eoi_level         = lv;
        model_step();
        @(negedge clk);
        #1;
        check_eq("int_out",   16'(bus.int_out),        16'(e_int));
        check_eq("freeze",    16'(bus.freeze),         16'(e_freeze));
        check_eq("clear_ir",  16'(bus.clear_ir_line),  16'(e_clear));
        check_eq("isr",       16'(bus.in_service_reg), 16'(m_isr));
        check_eq("dout_vld",  16'(bus.data_out_valid), 16'(e_valid));
        check_eq("data_out",  16'(bus.data_out),       16'(e_dout));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b1;
        bus.interrupt_req_reg = 0; bus.interrupt_mask = 0; bus.auto_eoi = 0;
        bus.rotate_mode = 0; bus.inta = 0; bus.eoi_cmd = 0; bus.eoi_specific = 0;
        bus.eoi_level = 0; bus.vector_base = 5'h15;
        cyc(8'h00, 0, 0, 0, 0);
        cyc(8'h00, 0, 0, 0, 0);
        check_eq("rst_isr", 16'(bus.in_service_reg), 16'h0);
        reset = 1'b0;

        // fixed priority: IR3 beats IR5
        cyc(8'h28, 0, 0, 0, 0);
        check_eq("fix_int", 16'(bus.int_out), 16'h1);
        cyc(8'h28, 1, 0, 0, 0);
        check_eq("fix_isr", 16'(bus.in_service_reg), 16'h08);
        check_eq("fix_clr", 16'(bus.clear_ir_line), 16'h08);
        cyc(8'h00, 1, 0, 0, 0);
        check_eq("fix_vec", 16'(bus.data_out), 16'hAB);
        cyc(8'h00, 0, 1, 0, 0);
        check_eq("fix_eoi", 16'(bus.in_service_reg), 16'h00);

        // nesting: IR2 in service blocks IR4, admits IR1
        cyc(8'h04, 0, 0, 0, 0);
        cyc(8'h04, 1, 0, 0, 0);
        cyc(8'h00, 1, 0, 0, 0);
        check_eq("nest_isr", 16'(bus.in_service_reg), 16'h04);
        cyc(8'h10, 0, 0, 0, 0);
        cyc(8'h10, 0, 0, 0, 0);
        check_eq("nest_blk", 16'(bus.int_out), 16'h0);
        cyc(8'h02, 0, 0, 0, 0);
        check_eq("nest_ok", 16'(bus.int_out), 16'h1);
        cyc(8'h02, 1, 0, 0, 0);
        cyc(8'h00, 1, 0, 0, 0);
        check_eq("nest_isr2", 16'(bus.in_service_reg), 16'h06);
        cyc(8'h00, 0, 1, 0, 0);
        cyc(8'h00, 0, 1, 0, 0);
        check_eq("nest_clr", 16'(bus.in_service_reg), 16'h00);

        // rotation: after IR0 EOI, IR7 outranks IR0
        bus.rotate_mode = 1;
        cyc(8'h01, 0, 0, 0, 0);
        cyc(8'h01, 1, 0, 0, 0);
        cyc(8'h00, 1, 0, 0, 0);
        cyc(8'h00, 0, 1, 0, 0);
        cyc(8'h81, 0, 0, 0, 0);
        cyc(8'h81, 1, 0, 0, 0);
        check_eq("rot_clr", 16'(bus.clear_ir_line), 16'h80);
        cyc(8'h01, 1, 0, 0, 0);
        check_eq("rot_vec", 16'(bus.data_out), 16'hAF);
        cyc(8'h00, 0, 1, 0, 0);
        check_eq("rot_eoi", 16'(bus.in_service_reg), 16'h00);
        bus.rotate_mode = 0;
        cyc(8'h00, 0, 0, 0, 0);

        // spurious: IR6 withdrawn before the first acknowledge
        cyc(8'h40, 0, 0, 0, 0);
        cyc(8'h00, 0, 0, 0, 0);
        check_eq("spur_hold", 16'(bus.int_out), 16'h1);
        cyc(8'h00, 1, 0, 0, 0);
        check_eq("spur_clr", 16'(bus.clear_ir_line), 16'h00);
        cyc(8'h00, 1, 0, 0, 0);
        check_eq("spur_vec", 16'(bus.data_out), 16'hAF);
        check_eq("spur_isr", 16'(bus.in_service_reg), 16'h00);

        // auto EOI, then specific EOI on an empty ISR
        bus.auto_eoi = 1;
        cyc(8'h08, 0, 0, 0, 0);
        cyc(8'h08, 1, 0, 0, 0);
        cyc(8'h00, 1, 0, 0, 0);
        check_eq("aeoi_vld", 16'(bus.data_out_valid), 16'h1);
        check_eq("aeoi_isr", 16'(bus.in_service_reg), 16'h00);
        cyc(8'h00, 0, 1, 1, 3'd5);
        check_eq("seoi_nop", 16'(bus.in_service_reg), 16'h00);
        bus.auto_eoi = 0;

        // reset between the two acknowledge pulses
        cyc(8'h10, 0, 0, 0, 0);
        cyc(8'h10, 1, 0, 0, 0);
        reset = 1'b1;
        cyc(8'h00, 0, 0, 0, 0);
        check_eq("mid_rst_frz", 16'(bus.freeze), 16'h0);
        reset = 1'b0;
        cyc(8'h00, 1, 0, 0, 0);
        check_eq("mid_rst_vld", 16'(bus.data_out_valid), 16'h0);

        // randomized traffic against the model
        for (int seg = 0; seg < 8; seg++) begin
            bus.rotate_mode = 1'($urandom_range(0, 1));
            bus.auto_eoi    = 1'($urandom_range(0, 1));
            for (int n = 0; n < 200; n++) begin
                logic [7:0] rq;
                reset              = ($urandom_range(0, 99) == 0);
                bus.interrupt_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
                bus.vector_base    = 5'($urandom);
                rq                 = 8'($urandom) & 8'($urandom);
                cyc(rq, ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
                    1'($urandom_range(0, 1)), 3'($urandom));
            end
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 Parameters: none. All vectors are fixed at 8 IR lines.
REQ-002 clk  in  1  single clock; all state updates on negedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 interrupt_req_reg  in  8  latched requests from the request register.
REQ-005 interrupt_mask  in  8  1 = line masked.
REQ-006 auto_eoi  in  1  1 = clear the in-service bit at the end of the acknowledge sequence.
REQ-007 rotate_mode  in  1  1 = rotating priority; 0 = fixed priority (IR0 highest).
REQ-008 inta  in  1  one-cycle strobe per CPU acknowledge pulse.
REQ-009 eoi_cmd  in  1  one-cycle EOI command strobe.
REQ-010 eoi_specific  in  1  qualifies eoi_cmd: 1 = specific EOI, 0 = non-specific.
REQ-011 eoi_level  in  3  IR level targeted by a specific EOI.
REQ-012 vector_base  in  5  vector bits T7..T3.
REQ-013 int_out  out  1  interrupt request to the CPU.
REQ-014 freeze  out  1  holds the request register during acknowledge.
REQ-015 clear_ir_line  out  8  one-hot, one-cycle clear of the acknowledged request.
REQ-016 in_service_reg  out  8  in-service register (ISR).
REQ-017 data_out  out  8  interrupt vector.
REQ-018 data_out_valid  out  1  one-cycle qualifier for data_out.

Function
REQ-019 Priority order SHALL start at (lowest_priority+1) mod 8 and wrap around; in fixed mode lowest_priority is held at 7.
REQ-020 A candidate is any bit of interrupt_req_reg & ~interrupt_mask.
REQ-021 A candidate SHALL be eligible only if its priority is strictly higher than the highest set ISR bit.
REQ-022 FSM states: IDLE, PENDING, ACK1. No other states.
REQ-023 IDLE -> PENDING when an eligible candidate exists; int_out SHALL be 1 from the cycle after the request is visible (latency 1).
REQ-024 PENDING, inta=1:
  - latch the winner;
  - set ISR[winner];
  - pulse clear_ir_line[winner] for one cycle;
  - set freeze=1 and int_out=0;
  - go to ACK1.
REQ-025 PENDING, inta=1 with no candidate left (request withdrawn): winner = 7 (spurious), ISR not set, clear_ir_line = 0, go to ACK1.
REQ-026 PENDING with the candidate withdrawn and no inta: stay in PENDING with int_out held at 1.
REQ-027 ACK1, inta=1:
  - data_out = {vector_base, winner}, data_out_valid=1 for one cycle;
  - freeze=0;
  - go to IDLE.
REQ-028 If auto_eoi=1 at the REQ-027 cycle, ISR[winner] SHALL be cleared in that cycle (not for a spurious winner), and lowest_priority SHALL be set to winner when rotate_mode=1.
REQ-029 ACK1 with no inta: hold state, freeze=1.
REQ-030 Non-specific EOI clears the highest-priority set ISR bit; specific EOI clears ISR[eoi_level].
REQ-031 With rotate_mode=1, an EOI SHALL set lowest_priority to the cleared level.
REQ-032 An EOI with no matching ISR bit set SHALL be a no-op, including no rotation.
REQ-033 EOI and the REQ-024 ISR set in the same cycle: the EOI is applied first, then the set, so the set wins on the same bit.
REQ-034 inta in IDLE SHALL be ignored.
REQ-035 eoi_cmd SHALL be accepted in every state.
REQ-036 Winner selection uses the priority order at the inta cycle; a rotation in the same cycle takes effect next cycle.

Reset
REQ-037 On reset=1 at negedge clk:
  - FSM = IDLE;
  - int_out=0, freeze=0, clear_ir_line=0, data_out_valid=0;
  - data_out=0, in_service_reg=0;
  - lowest_priority=7.
REQ-038 Reset mid-acknowledge SHALL abandon the sequence with no vector output and no ISR change beyond the REQ-037 reset values.

Structure
REQ-039 Shared package pic_pkg SHALL hold the FSM state typedef, NUM_IR=8, SPURIOUS_LEVEL=3'd7 and the rotate-by-N helper function.
REQ-040 One combinational sub-module, priority_resolver (8-bit vector + lowest_priority -> valid, 3-bit level), SHALL be instantiated twice: once for candidates, once for the ISR.

Verification
REQ-041 Fixed mode: IR3 and IR5 requested -> int_out at +1 cycle; inta, inta -> ISR=8'h08, clear_ir_line=8'h08, data_out={vector_base,3'd3}.
REQ-042 Nesting: ISR=8'h04 (IR2), request IR4 -> int_out stays 0. Then request IR1 -> int_out=1.
REQ-043 Rotation: rotate_mode=1, service IR0, non-specific EOI -> lowest_priority=0. IR0 and IR7 both requested -> IR1..IR7 order, IR7 wins.
REQ-044 Spurious: IR6 asserted, withdrawn before the first inta -> data_out={vector_base,3'd7}, ISR unchanged.
REQ-045 auto_eoi=1: after the second inta, ISR returns to 0 in the same cycle data_out_valid=1. A specific EOI on an empty ISR -> no change.
REQ-046 Reset asserted between the two inta pulses -> all outputs at reset values next cycle; the following inta produces no data_out_valid.
